h14tx_encoding_array: RTL and testbench
=======================================

Name: h14tx_encoding_array

Overview:
- Registered, multi-channel TMDS/TERC4/control/guard encoder for the HDMI 1.4 transmit path. It sits between the period scheduler and the serializers.
- Encodes `Chans` lanes in lock-step from one period value. Each lane has its own DC-balance disparity state.
- Adds a configurable output pipeline and a period-sequence checker with a sticky error flag. Neither is present in the single-lane encoder.

Parameters:
- Chans, 3, number of lanes encoded in parallel (1..4); lane i uses guard pattern of channel i mod 3.
- Latency, 1, output register stages (1 or 2); applies equally to symbols and seq_err path.
- CheckSeq, 1, 1 = period-sequence checker instantiated; 0 = seq_err tied to 0.

Ports:
- clk  input  1  pixel clock, sole clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- period  input  period_t  current period (Control, VideoPreamble, VideoGuard, VideoActive, DataIslandPreamble, DataIslandGuard, DataIslandActive).
- ctl  input  2*Chans  per-lane control bits, lane i at [2i+1:2i].
- data  input  4*Chans  per-lane TERC4 nibble, lane i at [4i+3:4i].
- video  input  8*Chans  per-lane pixel byte, lane i at [8i+7:8i].
- err_clr  input  1  clears seq_err.
- symbol  output  10*Chans  per-lane 10-bit symbol, lane i at [10i+9:10i], bit 0 sent first.
- seq_err  output  1  sticky period-sequence violation.

Behaviour:
- Reset: every symbol lane = 10'b1101010100 (ctl 00); all disparity counters = 0; seq_err = 0; run counter = 0; pipeline registers hold the reset symbol.
- Latency: the symbol for inputs sampled at edge N appears after edge N+Latency-1. Latency=1 means one register.
- Period select per lane:
  - VideoActive → TMDS.
  - DataIslandActive → TERC4(data).
  - VideoGuard, DataIslandGuard → guard.
  - All others → control.
- Control map: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
- TERC4: standard HDMI 1.4 16-entry table.
- Video guard by channel (i mod 3):
  - Channel 0 → 1011001100.
  - Channel 1 → 0100110011.
  - Channel 2 → 1011001100.
- Data island guard:
  - Channels 1 and 2 → 0100110011.
  - Channel 0 → TERC4(data) passthrough.
- TMDS encoding:
  - Full DVI 1.0 algorithm: XOR/XNOR minimisation, then conditional inversion by running disparity.
  - cnt is a 6-bit signed per-lane register. It updates only in cycles where period==VideoActive.
  - It is forced to 0 in any cycle where period!=VideoActive.
- Sequence checker (CheckSeq=1):
  - A 10-bit run counter counts consecutive cycles of the same period; it resets to 1 on each change.
  - On each change, the finished run is judged with these rules:
    - VideoPreamble must last exactly 8 cycles and be followed by VideoGuard.
    - VideoGuard must last exactly 2 and be followed by VideoActive.
    - DataIslandPreamble must last exactly 8 and be followed by DataIslandGuard.
    - A leading DataIslandGuard must last exactly 2 and be followed by DataIslandActive.
    - DataIslandActive length must be a multiple of 32, 32..576, and be followed by a 2-cycle DataIslandGuard.
    - VideoGuard or DataIslandGuard entered from any period other than its preamble or DataIslandActive is a violation.
  - The run counter saturates at 1023, so it never wraps.
  - A violation sets seq_err, with the same latency as symbols.
  - When err_clr and a new violation occur in the same cycle, set wins.
  - The checker only judges transitions. A run in progress at reset is discarded.
- Reset mid-operation returns all state to reset values on the next edge; there is no partial symbol.

Test Plan:
- Reset: hold rst 3 cycles, period=VideoActive → every lane 1101010100, seq_err=0 for the whole reset window and first Latency cycles after.
- TMDS disparity: lane 0 VideoActive, video=0x00 for 3 cycles from cnt=0 → symbols 0x100, 0x3FF, 0x100; internal cnt −8, +2, −6.
- Disparity reset: after the above, one Control cycle, then video=0x00 → 0x100 again (cnt restarted at 0).
- Guards: Chans=3, VideoPreamble×8 then VideoGuard×2 → lanes 0/1/2 = 1011001100 / 0100110011 / 1011001100; seq_err stays 0.
- Violation: VideoPreamble×7 then VideoGuard → seq_err=1 after Latency cycles; err_clr pulse with no further violation → 0 next cycle.
- Data island length and set-wins: DataIslandActive×33 then DataIslandGuard, with err_clr asserted in the violating cycle → seq_err=1. Repeat with Latency=2 → same response, one cycle later.

Source files
------------

// File: rtl/h14tx_encoding_array.sv
// Multi-lane HDMI 1.4 TX symbol encoder (TMDS / TERC4 / control / guard).
// Registered output with optional extra stage and a sticky period-sequence checker.
module h14tx_encoding_array #(
  parameter int Chans    = 3,
  parameter int Latency  = 1,
  parameter int CheckSeq = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            period,
  input  logic [2*Chans-1:0]    ctl,
  input  logic [4*Chans-1:0]    data,
  input  logic [8*Chans-1:0]    video,
  input  logic                  err_clr,
  output logic [10*Chans-1:0]   symbol,
  output logic                  seq_err
);

  localparam logic [2:0] P_CTRL   = 3'd0;
  localparam logic [2:0] P_VPRE   = 3'd1;
  localparam logic [2:0] P_VGUARD = 3'd2;
  localparam logic [2:0] P_VACT   = 3'd3;
  localparam logic [2:0] P_DPRE   = 3'd4;
  localparam logic [2:0] P_DGUARD = 3'd5;
  localparam logic [2:0] P_DACT   = 3'd6;

  localparam logic [9:0] SYM_RST  = 10'b1101010100;
  localparam logic [9:0] GUARD_A  = 10'b1011001100;
  localparam logic [9:0] GUARD_B  = 10'b0100110011;

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    case (d)
      4'h0: return 10'b1010011100;
      4'h1: return 10'b1001100011;
      4'h2: return 10'b1011100100;
      4'h3: return 10'b1011100010;
      4'h4: return 10'b0101110001;
      4'h5: return 10'b0100011110;
      4'h6: return 10'b0110001110;
      4'h7: return 10'b0100111100;
      4'h8: return 10'b1011001100;
      4'h9: return 10'b0100111001;
      4'hA: return 10'b0110011100;
      4'hB: return 10'b1011000110;
      4'hC: return 10'b1010001110;
      4'hD: return 10'b1001110001;
      4'hE: return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'b000, v[k]};
    return n;
  endfunction

  // Returns {next disparity, 10-bit symbol}.
  function automatic logic [15:0] tmds(input logic [7:0] d, input logic signed [5:0] cnt);
    logic [8:0]        qm;
    logic [3:0]        n1d;
    logic [3:0]        n1q;
    logic              use_xnor;
    logic signed [5:0] bal;
    logic signed [5:0] cnt_n;
    logic [9:0]        q;
    n1d      = ones8(d);
    use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !d[0]);
    qm[0]    = d[0];
    for (int k = 1; k < 8; k++) qm[k] = use_xnor ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
    qm[8]    = ~use_xnor;
    n1q      = ones8(qm[7:0]);
    bal      = $signed({1'b0, n1q, 1'b0}) - 6'sd8;
    if (cnt == 6'sd0 || bal == 6'sd0) begin
      q     = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      cnt_n = qm[8] ? (cnt + bal) : (cnt - bal);
    end else if ((cnt > 6'sd0 && bal > 6'sd0) || (cnt < 6'sd0 && bal < 6'sd0)) begin
      q     = {1'b1, qm[8], ~qm[7:0]};
      cnt_n = cnt + (qm[8] ? 6'sd2 : 6'sd0) - bal;
    end else begin
      q     = {1'b0, qm[8], qm[7:0]};
      cnt_n = cnt - (qm[8] ? 6'sd0 : 6'sd2) + bal;
    end
    return {cnt_n, q};
  endfunction

  function automatic logic [9:0] run_sat(input logic [9:0] r);
    return (r == 10'h3FF) ? r : r + 10'd1;
  endfunction

  logic [10*Chans-1:0] sym_d;
  logic [10*Chans-1:0] sym_p0;
  logic                viol;
  logic                err_p0;

  for (genvar i = 0; i < Chans; i++) begin : g_lane
    localparam int CH = i % 3;
    logic signed [5:0] cnt_q;
    logic [15:0]       tm;
    logic [9:0]        sym_l;

    always_comb begin
      tm    = tmds(video[8*i +: 8], cnt_q);
      sym_l = ctl_sym(ctl[2*i +: 2]);
      case (period)
        P_VACT:   sym_l = tm[9:0];
        P_DACT:   sym_l = terc4(data[4*i +: 4]);
        P_VGUARD: sym_l = (CH == 1) ? GUARD_B : GUARD_A;
        P_DGUARD: sym_l = (CH == 0) ? terc4(data[4*i +: 4]) : GUARD_B;
        default:  sym_l = ctl_sym(ctl[2*i +: 2]);
      endcase
    end

    // Disparity only survives across consecutive active-video cycles.
    always_ff @(posedge clk) begin
      if (rst || period != P_VACT) cnt_q <= 6'sd0;
      else                         cnt_q <= $signed(tm[15:10]);
    end

    assign sym_d[10*i +: 10] = sym_l;
  end

  if (CheckSeq != 0) begin : g_chk
    logic [2:0] prev_q;
    logic [9:0] run_q;
    logic       lead_q;

    always_comb begin
      viol = 1'b0;
      if (run_q != 10'd0 && period != prev_q) begin
        case (prev_q)
          P_VPRE:   viol = (run_q != 10'd8) || (period != P_VGUARD);
          P_VGUARD: viol = (run_q != 10'd2) || (period != P_VACT);
          P_DPRE:   viol = (run_q != 10'd8) || (period != P_DGUARD);
          P_DGUARD: viol = (run_q != 10'd2) || (lead_q && period != P_DACT);
          P_DACT:   viol = (run_q[4:0] != 5'd0) || (run_q < 10'd32) || (run_q > 10'd576)
                           || (period != P_DGUARD);
          default:  viol = 1'b0;
        endcase
        if (period == P_VGUARD && prev_q != P_VPRE) viol = 1'b1;
        if (period == P_DGUARD && prev_q != P_DPRE && prev_q != P_DACT) viol = 1'b1;
      end
    end

    // run_q == 0 marks "no run yet", so the first run after reset is never judged early.
    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q <= P_CTRL;
        run_q  <= 10'd0;
        lead_q <= 1'b0;
      end else if (run_q == 10'd0 || period != prev_q) begin
        prev_q <= period;
        run_q  <= 10'd1;
        lead_q <= (run_q != 10'd0) && (prev_q == P_DPRE);
      end else begin
        run_q  <= run_sat(run_q);
      end
    end
  end else begin : g_nochk
    assign viol = 1'b0;
  end

  // Stage p0: encoded symbols and sticky error (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_p0 <= {Chans{SYM_RST}};
      err_p0 <= 1'b0;
    end else begin
      sym_p0 <= sym_d;
      err_p0 <= viol | (err_p0 & ~err_clr);
    end
  end

  if (Latency == 2) begin : g_p1
    logic [10*Chans-1:0] sym_p1;
    logic                err_p1;

    // Stage p1: optional retiming stage.
    always_ff @(posedge clk) begin
      if (rst) begin
        sym_p1 <= {Chans{SYM_RST}};
        err_p1 <= 1'b0;
      end else begin
        sym_p1 <= sym_p0;
        err_p1 <= err_p0;
      end
    end
    assign symbol  = sym_p1;
    assign seq_err = err_p1;
  end else begin : g_p0
    assign symbol  = sym_p0;
    assign seq_err = err_p0;
  end

endmodule

// File: tb/tb_h14tx_encoding_array.sv
// Directed bench for h14tx_encoding_array: a Latency=1 and a Latency=2 instance share stimulus.
module tb_h14tx_encoding_array;

  localparam logic [2:0] P_CTRL   = 3'd0;
  localparam logic [2:0] P_VPRE   = 3'd1;
  localparam logic [2:0] P_VGUARD = 3'd2;
  localparam logic [2:0] P_VACT   = 3'd3;
  localparam logic [2:0] P_DPRE   = 3'd4;
  localparam logic [2:0] P_DGUARD = 3'd5;
  localparam logic [2:0] P_DACT   = 3'd6;

  localparam logic [9:0] RST_S = 10'b1101010100;
  localparam logic [29:0] RST3 = {RST_S, RST_S, RST_S};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  period;
  logic [5:0]  ctl;
  logic [11:0] data;
  logic [23:0] video;
  logic        err_clr;
  logic [29:0] sym1, sym2;
  logic        err1, err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  h14tx_encoding_array #(.Chans(3), .Latency(1), .CheckSeq(1)) dut (
    .clk(clk), .rst(rst), .period(period), .ctl(ctl), .data(data), .video(video),
    .err_clr(err_clr), .symbol(sym1), .seq_err(err1)
  );

  h14tx_encoding_array #(.Chans(3), .Latency(2), .CheckSeq(1)) dut2 (
    .clk(clk), .rst(rst), .period(period), .ctl(ctl), .data(data), .video(video),
    .err_clr(err_clr), .symbol(sym2), .seq_err(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; period = P_VACT; ctl = 6'd0; data = 12'd0; video = 24'd0; err_clr = 1'b0;

    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_sym", sym1, RST3);
      chk("rst_err", err1, 1'b0);
      chk("rst_sym_l2", sym2, RST3);
      chk("rst_err_l2", err2, 1'b0);
    end

    rst = 1'b0; video = {8'h00, 8'hFF, 8'h00};
    tick();
    chk("tmds_c1", sym1, {10'h100, 10'h200, 10'h100});
    chk("err_post_rst", err1, 1'b0);
    chk("sym_l2_first", sym2, RST3);
    chk("err_l2_first", err2, 1'b0);
    tick();
    chk("tmds_c2", sym1, {10'h3FF, 10'h0FF, 10'h3FF});
    chk("tmds_c1_l2", sym2, {10'h100, 10'h200, 10'h100});
    tick();
    chk("tmds_c3", sym1, {10'h100, 10'h0FF, 10'h100});
    chk("tmds_c2_l2", sym2, {10'h3FF, 10'h0FF, 10'h3FF});

    period = P_CTRL; ctl = {2'b11, 2'b10, 2'b01};
    tick();
    chk("ctl_map", sym1, {10'b1010101011, 10'b0101010100, 10'b0010101011});
    period = P_VACT;
    tick();
    chk("disp_restart", sym1, {10'h100, 10'h200, 10'h100});
    period = P_CTRL; ctl = 6'd0;
    tick();

    period = P_VPRE;
    repeat (8) tick();
    chk("vpre_ctl", sym1, RST3);
    period = P_VGUARD;
    tick();
    chk("vguard_1", sym1, {10'b1011001100, 10'b0100110011, 10'b1011001100});
    tick();
    chk("vguard_2", sym1, {10'b1011001100, 10'b0100110011, 10'b1011001100});
    chk("vguard_err", err1, 1'b0);
    period = P_VACT;
    tick();
    chk("vact_err", err1, 1'b0);
    period = P_CTRL;
    tick();

    period = P_VPRE;
    repeat (7) tick();
    period = P_VGUARD;
    tick();
    chk("short_pre_err", err1, 1'b1);
    chk("short_pre_err_l2_early", err2, 1'b0);
    tick();
    chk("short_pre_sticky", err1, 1'b1);
    chk("short_pre_err_l2", err2, 1'b1);
    period = P_VACT; err_clr = 1'b1;
    tick();
    chk("clr_err", err1, 1'b0);
    chk("clr_err_l2_early", err2, 1'b1);
    err_clr = 1'b0; period = P_CTRL;
    tick();
    chk("clr_stays", err1, 1'b0);
    chk("clr_err_l2", err2, 1'b0);

    data = {4'hF, 4'h5, 4'h0};
    period = P_DPRE;
    repeat (8) tick();
    period = P_DGUARD;
    tick();
    chk("dguard", sym1, {10'b0100110011, 10'b0100110011, 10'b1010011100});
    tick();
    period = P_DACT;
    repeat (33) tick();
    chk("terc4", sym1, {10'b1011000011, 10'b0100011110, 10'b1010011100});
    chk("dact_err_none", err1, 1'b0);
    period = P_DGUARD; err_clr = 1'b1;
    tick();
    chk("dact_len_setwins", err1, 1'b1);
    chk("dact_len_l2_early", err2, 1'b0);
    err_clr = 1'b0;
    tick();
    chk("dact_len_sticky", err1, 1'b1);
    chk("dact_len_l2", err2, 1'b1);

    rst = 1'b1; period = P_VACT;
    tick();
    chk("midrst_sym", sym1, RST3);
    chk("midrst_err", err1, 1'b0);
    chk("midrst_sym_l2", sym2, RST3);
    chk("midrst_err_l2", err2, 1'b0);
    rst = 1'b0;
    tick();
    chk("midrst_tmds", sym1, {10'h100, 10'h200, 10'h100});
    chk("midrst_err_after", err1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
